blink_monitor: RTL and testbench

- Receive-side checker for the LED blink generator output.
- Samples a single blink line and measures ON-run and OFF-run lengths in clock cycles.
- Reports each complete period, compares it against the expected ON/OFF times, and tracks lock and stuck status.
- Sits on the observation side of the blink path, for self-test or board-level pattern verification.

---
 rtl/blink_pkg.sv | 18 +
 rtl/blink_sync_edge.sv | 39 +++
 rtl/blink_monitor.sv | 217 +++++++++++++++++++++
 tb/tb_blink_monitor.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/blink_pkg.sv
// rtl/blink_pkg.sv - shared blink state encodings, line levels and default timing
package blink_pkg;

   typedef enum logic [1:0] {
      ACQ      = 2'b00,
      MEAS_ON  = 2'b01,
      MEAS_OFF = 2'b10
   } blink_state_e;

   // The generator drives ON as a low level on its bit 0
   localparam logic LED_ON_LEVEL  = 1'b0;
   localparam logic LED_OFF_LEVEL = 1'b1;

   // Default run lengths, shared with the blink generator
   localparam int unsigned BLINK_T_ON  = 5;
   localparam int unsigned BLINK_T_OFF = 4;

endpackage

// File: rtl/blink_sync_edge.sv
// rtl/blink_sync_edge.sv - 2-flop synchronizer with previous-level flop and edge flag
module blink_sync_edge #(
   parameter logic RST_VAL = 1'b1
) (
   input  logic clock,
   input  logic reset,
   input  logic din,
   output logic sync_level,
   output logic sync_edge
);

   logic s1_q, s1_d;
   logic s2_q, s2_d;
   logic prev_q, prev_d;

   // Shift the raw line through two stages, then keep one cycle of history
   always_comb begin
      s1_d   = din;
      s2_d   = s1_q;
      prev_d = s2_q;
   end

   // Synchronizer and history flops come out of reset at the idle level
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         s1_q   <= RST_VAL;
         s2_q   <= RST_VAL;
         prev_q <= RST_VAL;
      end else begin
         s1_q   <= s1_d;
         s2_q   <= s2_d;
         prev_q <= prev_d;
      end
   end

   assign sync_level = s2_q;
   assign sync_edge  = (s2_q != prev_q);

endmodule

// File: rtl/blink_monitor.sv
// rtl/blink_monitor.sv - blink line checker; BLINK_MON_STATS_EN adds ok/err counters
module blink_monitor
   import blink_pkg::*;
#(
   parameter int unsigned T_ON        = BLINK_T_ON,
   parameter int unsigned T_OFF       = BLINK_T_OFF,
   parameter int unsigned TOL         = 0,
   parameter int unsigned CNT_W       = 8,
   parameter int unsigned LOCK_N      = 3,
   parameter int unsigned STUCK_LIMIT = 200,
   parameter logic        ON_LEVEL    = LED_ON_LEVEL
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             blink_in,
   output logic             meas_valid,
   output logic [CNT_W-1:0] meas_on,
   output logic [CNT_W-1:0] meas_off,
   output logic             pattern_ok,
   output logic             mismatch,
   output logic             locked,
`ifdef BLINK_MON_STATS_EN
   output logic [15:0]      ok_cnt,
   output logic [15:0]      err_cnt,
`endif
   output logic             stuck
);

   localparam int unsigned LCK_W = $clog2(LOCK_N + 1);
   localparam logic [CNT_W-1:0]        CNT_MAX   = '1;
   localparam logic [CNT_W-1:0]        STUCK_VAL = CNT_W'(STUCK_LIMIT);
   localparam logic [LCK_W-1:0]        LOCK_MAX  = LCK_W'(LOCK_N);
   localparam logic signed [CNT_W:0]   T_ON_S    = (CNT_W+1)'(T_ON);
   localparam logic signed [CNT_W:0]   T_OFF_S   = (CNT_W+1)'(T_OFF);
   localparam logic signed [CNT_W:0]   TOL_S     = (CNT_W+1)'(TOL);

   // Absolute deviation of a run from its target, one bit wider and signed
   function automatic logic in_tol(input logic [CNT_W-1:0] run,
                                   input logic signed [CNT_W:0] tgt);
      logic signed [CNT_W:0] diff;
      diff = $signed({1'b0, run}) - tgt;
      if (diff < 0) diff = -diff;
      return (diff <= TOL_S);
   endfunction

   logic sync_level;
   logic sync_edge;

   blink_sync_edge #(
      .RST_VAL (~ON_LEVEL)
   ) u_sync (
      .clock      (clock),
      .reset      (reset),
      .din        (blink_in),
      .sync_level (sync_level),
      .sync_edge  (sync_edge)
   );

   blink_state_e     state_q, state_d;
   logic [CNT_W-1:0] run_cnt_q, run_cnt_d;
   logic [CNT_W-1:0] shadow_q, shadow_d;
   logic [LCK_W-1:0] lock_cnt_q, lock_cnt_d;
   logic             discard_q, discard_d;
   logic             meas_valid_q, meas_valid_d;
   logic [CNT_W-1:0] meas_on_q, meas_on_d;
   logic [CNT_W-1:0] meas_off_q, meas_off_d;
   logic             pattern_ok_q, pattern_ok_d;
   logic             mismatch_q, mismatch_d;
   logic             locked_q, locked_d;
   logic             stuck_q, stuck_d;
`ifdef BLINK_MON_STATS_EN
   logic [15:0]      ok_cnt_q, ok_cnt_d;
   logic [15:0]      err_cnt_q, err_cnt_d;
`endif

   logic [CNT_W-1:0] cnt_inc;
   logic             stuck_hit;
   logic             period_done;
   logic             period_ok;

   // Run counter: restart at 1 on every edge, otherwise count up and saturate
   always_comb begin
      cnt_inc     = (run_cnt_q == CNT_MAX) ? run_cnt_q : run_cnt_q + CNT_W'(1);
      run_cnt_d   = sync_edge ? CNT_W'(1) : cnt_inc;
      // Fires once on reaching the limit; an edge in the same cycle wins
      stuck_hit   = !sync_edge && (cnt_inc == STUCK_VAL) && (run_cnt_q != STUCK_VAL);
      period_done = sync_edge && (state_q == MEAS_OFF);
      period_ok   = in_tol(shadow_q, T_ON_S) && in_tol(run_cnt_q, T_OFF_S);
   end

   // FSM state register
   always_ff @(posedge clock or posedge reset) begin
      if (reset) state_q <= ACQ;
      else       state_q <= state_d;
   end

   // FSM next state: a stuck line always forces reacquisition
   always_comb begin
      state_d = state_q;
      if (stuck_hit) begin
         state_d = ACQ;
      end else begin
         case (state_q)
            ACQ:      if (sync_edge && (sync_level == ON_LEVEL)) state_d = MEAS_ON;
            MEAS_ON:  if (sync_edge) state_d = MEAS_OFF;
            MEAS_OFF: if (sync_edge) state_d = MEAS_ON;
            default:  state_d = ACQ;
         endcase
      end
   end

   // FSM outputs: shadow capture, period report, lock and stuck tracking
   always_comb begin
      shadow_d     = shadow_q;
      lock_cnt_d   = lock_cnt_q;
      discard_d    = discard_q;
      meas_valid_d = 1'b0;
      meas_on_d    = meas_on_q;
      meas_off_d   = meas_off_q;
      pattern_ok_d = pattern_ok_q;
      mismatch_d   = 1'b0;
      locked_d     = locked_q;
      stuck_d      = stuck_q;
`ifdef BLINK_MON_STATS_EN
      ok_cnt_d     = ok_cnt_q;
      err_cnt_d    = err_cnt_q;
`endif

      if (state_q == MEAS_ON && sync_edge) shadow_d = run_cnt_q;

      if (sync_edge) stuck_d = 1'b0;

      if (stuck_hit) begin
         stuck_d    = 1'b1;
         locked_d   = 1'b0;
         lock_cnt_d = '0;
         discard_d  = 1'b1;
`ifdef BLINK_MON_STATS_EN
         if (err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
`endif
      end else if (period_done) begin
         if (discard_q) begin
            // The period begun during acquisition has an unreliable history
            discard_d = 1'b0;
         end else begin
            meas_valid_d = 1'b1;
            meas_on_d    = shadow_q;
            meas_off_d   = run_cnt_q;
            pattern_ok_d = period_ok;
            mismatch_d   = !period_ok;
            if (period_ok) begin
               if (lock_cnt_q != LOCK_MAX) lock_cnt_d = lock_cnt_q + LCK_W'(1);
               locked_d = (lock_cnt_d == LOCK_MAX);
`ifdef BLINK_MON_STATS_EN
               if (ok_cnt_q != 16'hFFFF) ok_cnt_d = ok_cnt_q + 16'd1;
`endif
            end else begin
               lock_cnt_d = '0;
               locked_d   = 1'b0;
`ifdef BLINK_MON_STATS_EN
               if (err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
`endif
            end
         end
      end
   end

   // Datapath and output registers
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         run_cnt_q    <= '0;
         shadow_q     <= '0;
         lock_cnt_q   <= '0;
         discard_q    <= 1'b1;
         meas_valid_q <= 1'b0;
         meas_on_q    <= '0;
         meas_off_q   <= '0;
         pattern_ok_q <= 1'b0;
         mismatch_q   <= 1'b0;
         locked_q     <= 1'b0;
         stuck_q      <= 1'b0;
`ifdef BLINK_MON_STATS_EN
         ok_cnt_q     <= '0;
         err_cnt_q    <= '0;
`endif
      end else begin
         run_cnt_q    <= run_cnt_d;
         shadow_q     <= shadow_d;
         lock_cnt_q   <= lock_cnt_d;
         discard_q    <= discard_d;
         meas_valid_q <= meas_valid_d;
         meas_on_q    <= meas_on_d;
         meas_off_q   <= meas_off_d;
         pattern_ok_q <= pattern_ok_d;
         mismatch_q   <= mismatch_d;
         locked_q     <= locked_d;
         stuck_q      <= stuck_d;
`ifdef BLINK_MON_STATS_EN
         ok_cnt_q     <= ok_cnt_d;
         err_cnt_q    <= err_cnt_d;
`endif
      end
   end

   assign meas_valid = meas_valid_q;
   assign meas_on    = meas_on_q;
   assign meas_off   = meas_off_q;
   assign pattern_ok = pattern_ok_q;
   assign mismatch   = mismatch_q;
   assign locked     = locked_q;
   assign stuck      = stuck_q;
`ifdef BLINK_MON_STATS_EN
   assign ok_cnt     = ok_cnt_q;
   assign err_cnt    = err_cnt_q;
`endif

endmodule

// File: tb/tb_blink_monitor.sv
// tb/tb_blink_monitor.sv - directed table-driven bench for blink_monitor
module tb_blink_monitor;

   localparam logic ON  = 1'b0;
   localparam logic OFF = 1'b1;

   logic clock;
   logic reset;
   logic blink_in;

   logic       meas_valid0, pattern_ok0, mismatch0, locked0, stuck0;
   logic [7:0] meas_on0, meas_off0;
   logic       meas_valid1, pattern_ok1, mismatch1, locked1, stuck1;
   logic [7:0] meas_on1, meas_off1;
   logic       meas_valid2, pattern_ok2, mismatch2, locked2, stuck2;
   logic [3:0] meas_on2, meas_off2;
`ifdef BLINK_MON_STATS_EN
   logic [15:0] ok_cnt0, err_cnt0, ok_cnt1, err_cnt1, ok_cnt2, err_cnt2;
`endif

   int n_cmp = 0;
   int n_err = 0;

   blink_monitor dut0 (
      .clock(clock), .reset(reset), .blink_in(blink_in),
      .meas_valid(meas_valid0), .meas_on(meas_on0), .meas_off(meas_off0),
      .pattern_ok(pattern_ok0), .mismatch(mismatch0), .locked(locked0),
`ifdef BLINK_MON_STATS_EN
      .ok_cnt(ok_cnt0), .err_cnt(err_cnt0),
`endif
      .stuck(stuck0)
   );

   blink_monitor #(.TOL(1)) dut1 (
      .clock(clock), .reset(reset), .blink_in(blink_in),
      .meas_valid(meas_valid1), .meas_on(meas_on1), .meas_off(meas_off1),
      .pattern_ok(pattern_ok1), .mismatch(mismatch1), .locked(locked1),
`ifdef BLINK_MON_STATS_EN
      .ok_cnt(ok_cnt1), .err_cnt(err_cnt1),
`endif
      .stuck(stuck1)
   );

   blink_monitor #(.CNT_W(4), .STUCK_LIMIT(15)) dut2 (
      .clock(clock), .reset(reset), .blink_in(blink_in),
      .meas_valid(meas_valid2), .meas_on(meas_on2), .meas_off(meas_off2),
      .pattern_ok(pattern_ok2), .mismatch(mismatch2), .locked(locked2),
`ifdef BLINK_MON_STATS_EN
      .ok_cnt(ok_cnt2), .err_cnt(err_cnt2),
`endif
      .stuck(stuck2)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct {
      int on_len;
      int off_len;
      bit rep;
      int exp_on;
      int exp_off;
      bit ok0;
      bit lock0;
      bit ok1;
      bit lock1;
   } vec_t;

   vec_t v [19];

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Report of period i, sampled on the 3rd edge after the next ON change
   task automatic check_vec(input int i);
      if (v[i].rep) begin
         chk($sformatf("v%0d valid0", i), 16'(meas_valid0), 16'd1);
         chk($sformatf("v%0d on0", i), 16'(meas_on0), 16'(v[i].exp_on));
         chk($sformatf("v%0d off0", i), 16'(meas_off0), 16'(v[i].exp_off));
         chk($sformatf("v%0d ok0", i), 16'(pattern_ok0), 16'(v[i].ok0));
         chk($sformatf("v%0d mis0", i), 16'(mismatch0), 16'(!v[i].ok0));
         chk($sformatf("v%0d lock0", i), 16'(locked0), 16'(v[i].lock0));
         chk($sformatf("v%0d valid1", i), 16'(meas_valid1), 16'd1);
         chk($sformatf("v%0d ok1", i), 16'(pattern_ok1), 16'(v[i].ok1));
         chk($sformatf("v%0d mis1", i), 16'(mismatch1), 16'(!v[i].ok1));
         chk($sformatf("v%0d lock1", i), 16'(locked1), 16'(v[i].lock1));
      end else begin
         chk($sformatf("v%0d disc_valid0", i), 16'(meas_valid0), 16'd0);
         chk($sformatf("v%0d disc_mis0", i), 16'(mismatch0), 16'd0);
         chk($sformatf("v%0d disc_on0", i), 16'(meas_on0), 16'(v[i].exp_on));
         chk($sformatf("v%0d disc_off0", i), 16'(meas_off0), 16'(v[i].exp_off));
         chk($sformatf("v%0d disc_valid1", i), 16'(meas_valid1), 16'd0);
      end
   endtask

   task automatic idle_chk();
      chk("idle_valid0", 16'(meas_valid0), 16'd0);
      chk("idle_valid1", 16'(meas_valid1), 16'd0);
   endtask

   task automatic drive_level(input logic lvl, input int n, input int chk_idx);
      blink_in = lvl;
      for (int k = 1; k <= n; k++) begin
         tick();
         if (k == 3 && chk_idx >= 0) check_vec(chk_idx);
         else idle_chk();
      end
   endtask

   task automatic run_periods(input int lo, input int hi);
      for (int i = lo; i <= hi; i++) begin
         drive_level(ON, v[i].on_len, (i == lo) ? -1 : i - 1);
         drive_level(OFF, v[i].off_len, -1);
      end
   endtask

   initial begin
      //          on off rep  eon eoff ok0 lk0 ok1 lk1
      v[0]  = '{5, 4, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0};
      v[1]  = '{5, 4, 1'b1, 5, 4, 1'b1, 1'b0, 1'b1, 1'b0};
      v[2]  = '{5, 4, 1'b1, 5, 4, 1'b1, 1'b0, 1'b1, 1'b0};
      v[3]  = '{5, 4, 1'b1, 5, 4, 1'b1, 1'b1, 1'b1, 1'b1};
      v[4]  = '{5, 4, 1'b1, 5, 4, 1'b1, 1'b1, 1'b1, 1'b1};
      v[5]  = '{6, 4, 1'b1, 6, 4, 1'b0, 1'b0, 1'b1, 1'b1};
      v[6]  = '{5, 4, 1'b1, 5, 4, 1'b1, 1'b0, 1'b1, 1'b1};
      v[7]  = '{5, 4, 1'b1, 5, 4, 1'b1, 1'b0, 1'b1, 1'b1};
      v[8]  = '{5, 3, 1'b1, 5, 3, 1'b0, 1'b0, 1'b1, 1'b1};
      v[9]  = '{4, 5, 1'b1, 4, 5, 1'b0, 1'b0, 1'b1, 1'b1};
      v[10] = '{7, 4, 1'b1, 7, 4, 1'b0, 1'b0, 1'b0, 1'b0};
      v[11] = '{5, 4, 1'b1, 5, 4, 1'b1, 1'b0, 1'b1, 1'b0};
      v[12] = '{5, 4, 1'b1, 5, 4, 1'b1, 1'b0, 1'b1, 1'b0};
      v[13] = '{5, 4, 1'b1, 5, 4, 1'b1, 1'b1, 1'b1, 1'b1};
      v[14] = '{5, 4, 1'b0, 5, 4, 1'b0, 1'b0, 1'b0, 1'b0};
      v[15] = '{5, 4, 1'b1, 5, 4, 1'b1, 1'b0, 1'b1, 1'b0};
      v[16] = '{5, 4, 1'b1, 5, 4, 1'b1, 1'b0, 1'b1, 1'b0};
      v[17] = '{5, 4, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0};
      v[18] = '{5, 4, 1'b1, 5, 4, 1'b1, 1'b0, 1'b1, 1'b0};

      reset    = 1'b1;
      blink_in = OFF;
      tick();
      tick();
      chk("rst valid0", 16'(meas_valid0), 16'd0);
      chk("rst on0", 16'(meas_on0), 16'd0);
      chk("rst off0", 16'(meas_off0), 16'd0);
      chk("rst ok0", 16'(pattern_ok0), 16'd0);
      chk("rst mis0", 16'(mismatch0), 16'd0);
      chk("rst lock0", 16'(locked0), 16'd0);
      chk("rst stuck0", 16'(stuck0), 16'd0);
      reset = 1'b0;
      drive_level(OFF, 3, -1);

      run_periods(0, 13);

      // Line held ON for 250 cycles: stuck 202 edges after the change
      blink_in = ON;
      for (int k = 1; k <= 250; k++) begin
         tick();
         if (k == 3) check_vec(13);
         else idle_chk();
         if (k == 16) chk("stuck2 pre", 16'(stuck2), 16'd0);
         if (k == 17) chk("stuck2 at", 16'(stuck2), 16'd1);
         if (k == 20) begin
            chk("cnt2 sat", 16'(dut2.run_cnt_q), 16'd15);
            chk("on2 held", 16'(meas_on2), 16'd5);
         end
         if (k == 201) begin
            chk("stuck0 pre", 16'(stuck0), 16'd0);
            chk("stuck1 pre", 16'(stuck1), 16'd0);
            chk("lock0 pre", 16'(locked0), 16'd1);
         end
         if (k == 202) begin
            chk("stuck0 at", 16'(stuck0), 16'd1);
            chk("stuck1 at", 16'(stuck1), 16'd1);
            chk("lock0 stuck", 16'(locked0), 16'd0);
            chk("lock1 stuck", 16'(locked1), 16'd0);
         end
         if (k == 250) begin
            chk("stuck0 hold", 16'(stuck0), 16'd1);
            chk("stuck2 hold", 16'(stuck2), 16'd1);
            chk("cnt2 sat end", 16'(dut2.run_cnt_q), 16'd15);
            chk("on2 no wrap", 16'(meas_on2), 16'd5);
         end
      end

      // Resume: first edge clears stuck
      blink_in = OFF;
      for (int k = 1; k <= 4; k++) begin
         tick();
         idle_chk();
         if (k == 2) chk("stuck0 until edge", 16'(stuck0), 16'd1);
         if (k == 3) begin
            chk("stuck0 cleared", 16'(stuck0), 16'd0);
            chk("stuck2 cleared", 16'(stuck2), 16'd0);
         end
      end

      run_periods(14, 16);

      // Reset asserted mid OFF run
      drive_level(ON, 5, 16);
      blink_in = OFF;
      for (int k = 1; k <= 4; k++) begin
         tick();
         idle_chk();
      end
      chk("pre rst ok0", 16'(pattern_ok0), 16'd1);
      #3 reset = 1'b1;
      #1;
      chk("arst valid0", 16'(meas_valid0), 16'd0);
      chk("arst on0", 16'(meas_on0), 16'd0);
      chk("arst off0", 16'(meas_off0), 16'd0);
      chk("arst ok0", 16'(pattern_ok0), 16'd0);
      chk("arst mis0", 16'(mismatch0), 16'd0);
      chk("arst lock0", 16'(locked0), 16'd0);
      chk("arst stuck0", 16'(stuck0), 16'd0);
      chk("arst on1", 16'(meas_on1), 16'd0);
      tick();
      tick();
      reset = 1'b0;
      drive_level(OFF, 3, -1);

      run_periods(17, 18);
      drive_level(ON, 5, 18);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
